// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state encodings and stream constants
//
// Purpose: common definitions for the instruction-memory program loader.
// Contents:
//   BYTE_W       - width of one stream byte
//   WORD_W       - width of an instruction word / header count
//   BYTES_PER_W  - stream bytes per word
//   ldr_state_e  - loader FSM states
package imem_loader_pkg;

    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 32;
    localparam int BYTES_PER_W = WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_HDR  = 3'd1,
        LDR_DATA = 3'd2,
        LDR_FIN  = 3'd3,
        LDR_DONE = 3'd4,
        LDR_ERR  = 3'd5
    } ldr_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian byte-to-word packer
//
// Purpose: assembles four accepted stream bytes into one 32-bit word, first
// byte in bits [31:24]. Used for both the header count and the data words.
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   synchronous active-low reset
//   in_byte    in   stream byte
//   accept     in   byte is being accepted this cycle
//   clear      in   restart assembly at byte 0
//   word       out  assembled word including the byte currently on in_byte
//   word_done  out  the 4th byte of a word is being accepted this cycle
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              accept,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = '0;
        end else if (accept) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[WORD_W-BYTE_W-1:0], in_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // The word is complete in the same cycle its last byte arrives, so the
    // consumer can register it without waiting for the shift register.
    assign word      = {shift_q[WORD_W-BYTE_W-1:0], in_byte};
    assign word_done = accept && !clear && (cnt_q == 2'(BYTES_PER_W - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial program loader writing instruction memory
//
// Purpose: accepts a big-endian byte stream (4-byte word count, then words)
// and issues one registered 32-bit write per word starting at ADDR_OFFSET.
// busy holds the CPU in reset while a load is in progress.
// Parameters:
//   ADDR_WIDTH   byte-address width of instruction memory
//   ADDR_OFFSET  byte address of the first instruction word
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-low reset
//   start     in   begin a load (honoured in IDLE, DONE, ERR)
//   in_data   in   stream byte
//   in_valid  in   in_data valid
//   in_ready  out  loader accepts a byte this cycle
//   wr_en     out  one-cycle write strobe
//   wr_addr   out  word-aligned byte address of the write
//   wr_data   out  instruction word
//   busy      out  load in progress
//   done      out  sticky, load completed
//   error     out  sticky, header count exceeded capacity
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] ADDR_OFFSET = 32'h3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] MEM_WORDS = 32'd1 << (ADDR_WIDTH - 2);

    ldr_state_e        state_q, state_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic              accept;
    logic              pk_clear;
    logic [WORD_W-1:0] pk_word;
    logic              pk_done;

    // Ready depends on registered state only: no path from in_valid.
    assign in_ready = (state_q == LDR_HDR) || (state_q == LDR_DATA);
    assign accept   = in_valid && in_ready;

    byte_packer u_packer (
        .clk       (clk),
        .resetn    (reset),
        .in_byte   (in_data),
        .accept    (accept),
        .clear     (pk_clear),
        .word      (pk_word),
        .word_done (pk_done)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pk_clear  = 1'b0;

        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
                if (start) begin
                    state_d  = LDR_HDR;
                    pk_clear = 1'b1;
                    count_d  = '0;
                    idx_d    = '0;
                end
            end
            LDR_HDR: begin
                if (pk_done) begin
                    count_d = pk_word;
                    idx_d   = '0;
                    if (pk_word == 32'd0) begin
                        state_d = LDR_DONE;
                    end else if (pk_word > MEM_WORDS) begin
                        state_d = LDR_ERR;
                    end else begin
                        state_d = LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                if (pk_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_OFFSET + (idx_q << 2);
                    wr_data_d = pk_word;
                    if (idx_q == count_q - 32'd1) begin
                        state_d = LDR_FIN;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            end
            // The last write strobe is on the bus during this state.
            LDR_FIN: begin
                state_d = LDR_DONE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= LDR_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == LDR_HDR) || (state_q == LDR_DATA) || (state_q == LDR_FIN);
    assign done    = (state_q == LDR_DONE);
    assign error   = (state_q == LDR_ERR);

endmodule
